shift_operand_issuer: RTL and testbench

- Front end of the 32-bit barrel shifter interface. It decodes the operand2 field of an ARM data-processing instruction and fetches Rm/Rs from the register file.
- It presents Shift_Data, Shift_Num, SHIFT_OP and Carry_flag to the shifter under a valid/ready handshake.
- It sits between the decode stage and barrelshifter32 and is the producer of every shifter command.

---
 rtl/shift_operand_issuer.sv | 180 ++++++++++++++++++
 tb/tb_shift_operand_issuer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_operand_issuer.sv
// shift_operand_issuer
//   Front end of the 32-bit barrel shifter. It decodes the operand2 field of an
//   ARM data-processing instruction, reads Rm/Rs from the register file, and
//   hands one complete shifter command to barrelshifter32 over a valid/ready
//   handshake. Only one instruction is in flight at a time.
//
// Ports
//   clk, rst_n        system clock, synchronous active-low reset
//   instr/instr_valid/instr_ready   instruction input handshake (accepted in IDLE)
//   cpsr_c, pc        C flag and instruction address, latched at accept
//   rf_re/rf_addr     register-file read request; rf_data returns one cycle later
//   Shift_Data, Shift_Num, SHIFT_OP, Carry_flag   shifter command fields
//   out_valid/out_ready   command handshake towards the shifter
//
// Optional feature
//   OPERAND_PC_FWD_EN : when defined, reads of R15 (as Rm or Rs) take the
//   latched pc + PC_OFFSET instead of rf_data. The read is still issued, so the
//   timing is identical in both builds.
//
// State table
//   state    | meaning
//   IDLE     | instr_ready=1, waiting for an instruction
//   RD_RM    | read request for Rm
//   CAP_RM   | capture Rm; for register shifts also issue the Rs read
//   CAP_RS   | capture low byte of Rs as the shift amount
//   ISSUE    | out_valid=1, command held until out_ready

module shift_operand_issuer #(
  parameter int RF_AW     = 4,
  parameter int PC_OFFSET = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             cpsr_c,
  input  logic [31:0]      pc,
  output logic             rf_re,
  output logic [RF_AW-1:0] rf_addr,
  input  logic [31:0]      rf_data,
  output logic [31:0]      Shift_Data,
  output logic [7:0]       Shift_Num,
  output logic [2:0]       SHIFT_OP,
  output logic             Carry_flag,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_RM  = 3'd1;
  localparam logic [2:0] S_CAP_RM = 3'd2;
  localparam logic [2:0] S_CAP_RS = 3'd3;
  localparam logic [2:0] S_ISSUE  = 3'd4;

  logic [2:0]       r_state;
  logic             r_in_rst;
  logic [11:0]      r_op2;
  logic             r_carry;
  logic [31:0]      r_data;
  logic [7:0]       r_num;
  logic [2:0]       r_sop;
  logic [RF_AW-1:0] r_rf_addr;

  logic             w_accept;
  logic             w_reg_shift;
  logic             w_rd_rm;
  logic             w_rd_rs;
  logic [31:0]      w_rm_val;
  logic [7:0]       w_rs_val;
  logic             w_unused_instr;

  // r_in_rst keeps instr_ready low in every cycle that follows a reset edge,
  // so the port reads 0 while reset is held and 1 from the first free cycle.
  assign instr_ready = (r_state == S_IDLE) && !r_in_rst;
  assign w_accept    = instr_valid && instr_ready;
  assign w_reg_shift = r_op2[4];

  assign w_rd_rm = (r_state == S_RD_RM);
  assign w_rd_rs = (r_state == S_CAP_RM) && w_reg_shift;
  assign rf_re   = w_rd_rm || w_rd_rs;

  // Address is only meaningful with rf_re; otherwise it parks on the last value.
  assign rf_addr = w_rd_rm ? RF_AW'(r_op2[3:0]) :
                   w_rd_rs ? RF_AW'(r_op2[11:8]) :
                   r_rf_addr;

  assign out_valid  = (r_state == S_ISSUE);
  assign Shift_Data = r_data;
  assign Shift_Num  = r_num;
  assign SHIFT_OP   = r_sop;
  assign Carry_flag = r_carry;

  // Only operand2 and the immediate flag are needed after accept.
  assign w_unused_instr = ^{instr[31:26], instr[24:12]};

`ifdef OPERAND_PC_FWD_EN
  logic [31:0] r_pc;
  logic [31:0] w_pc_fwd;

  assign w_pc_fwd = r_pc + 32'(PC_OFFSET);
  assign w_rm_val = (r_op2[3:0]  == 4'hF) ? w_pc_fwd      : rf_data;
  assign w_rs_val = (r_op2[11:8] == 4'hF) ? w_pc_fwd[7:0] : rf_data[7:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= 32'h0;
    end else if ((r_state == S_IDLE) && w_accept) begin
      r_pc <= pc;
    end
  end
`else
  logic w_unused_pc;

  assign w_rm_val    = rf_data;
  assign w_rs_val    = rf_data[7:0];
  assign w_unused_pc = ^{pc, 32'(PC_OFFSET)};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_in_rst  <= 1'b1;
      r_op2     <= 12'h0;
      r_carry   <= 1'b0;
      r_data    <= 32'h0;
      r_num     <= 8'h0;
      r_sop     <= 3'b000;
      r_rf_addr <= '0;
    end else begin
      r_in_rst  <= 1'b0;
      r_rf_addr <= rf_addr;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op2   <= instr[11:0];
            r_carry <= cpsr_c;
            if (instr[25]) begin
              // Rotated immediate: ROR by twice the 4-bit rotate field.
              r_data  <= {24'h0, instr[7:0]};
              r_num   <= {3'b000, instr[11:8], 1'b0};
              r_sop   <= 3'b110;
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_RD_RM;
            end
          end
        end
        S_RD_RM: begin
          r_state <= S_CAP_RM;
        end
        S_CAP_RM: begin
          r_data <= w_rm_val;
          if (w_reg_shift) begin
            r_sop   <= {r_op2[6:5], 1'b1};
            r_state <= S_CAP_RS;
          end else begin
            // Amount 0 passes through raw; the shifter decodes RRX / #32.
            r_num   <= {3'b000, r_op2[11:7]};
            r_sop   <= {r_op2[6:5], 1'b0};
            r_state <= S_ISSUE;
          end
        end
        S_CAP_RS: begin
          r_num   <= w_rs_val;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_operand_issuer.sv
// Bench for shift_operand_issuer: directed instructions with literal
// expectations, plus a cycle-by-cycle reference model of the handshake,
// register-file reads and command fields.

module tb_shift_operand_issuer;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        cpsr_c;
  logic [31:0] pc;
  logic        rf_re;
  logic [3:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] Shift_Data;
  logic [7:0]  Shift_Num;
  logic [2:0]  SHIFT_OP;
  logic        Carry_flag;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [31:0] regs [16];

  shift_operand_issuer #(.RF_AW(4), .PC_OFFSET(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .cpsr_c      (cpsr_c),
    .pc          (pc),
    .rf_re       (rf_re),
    .rf_addr     (rf_addr),
    .rf_data     (rf_data),
    .Shift_Data  (Shift_Data),
    .Shift_Num   (Shift_Num),
    .SHIFT_OP    (SHIFT_OP),
    .Carry_flag  (Carry_flag),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Register file: synchronous read, garbage when not reading.
  always @(posedge clk) begin
    if (rf_re) rf_data <= regs[rf_addr];
    else       rf_data <= 32'hDEADBEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // What the shifter must receive for an instruction, and the accept-to-valid latency.
  task automatic model_cmd(input logic [31:0] ins, input logic [31:0] p,
                           output logic [31:0] d, output logic [7:0] n,
                           output logic [2:0] op, output int lat);
    logic [31:0] rm_val;
    logic [31:0] rs_val;
    rm_val = regs[ins[3:0]];
    rs_val = regs[ins[11:8]];
`ifdef OPERAND_PC_FWD_EN
    if (ins[3:0]  == 4'hF) rm_val = p + 32'd8;
    if (ins[11:8] == 4'hF) rs_val = p + 32'd8;
`else
    if (p == 32'hFFFF_FFFF) rm_val = rm_val;
`endif
    if (ins[25]) begin
      d   = {24'h0, ins[7:0]};
      n   = 8'(ins[11:8]) * 8'd2;
      op  = 3'b110;
      lat = 1;
    end else if (!ins[4]) begin
      d   = rm_val;
      n   = 8'(ins[11:7]);
      op  = {ins[6:5], 1'b0};
      lat = 3;
    end else begin
      d   = rm_val;
      n   = rs_val[7:0];
      op  = {ins[6:5], 1'b1};
      lat = 4;
    end
  endtask

  // Per-cycle compare against the model.
  initial begin : mon
    logic        m_armed, m_in_rst, m_busy, m_imm, m_regsh, m_c;
    logic [31:0] m_d;
    logic [7:0]  m_n;
    logic [2:0]  m_op;
    logic [3:0]  m_rm, m_rs, m_last, exp_addr;
    int          m_acc, m_vat, lat;
    logic        exp_ov, exp_re;
    m_armed = 0; m_in_rst = 0; m_busy = 0; m_imm = 0; m_regsh = 0; m_c = 0;
    m_d = 0; m_n = 0; m_op = 0; m_rm = 0; m_rs = 0; m_last = 0;
    m_acc = 0; m_vat = 0; lat = 0;
    forever begin
      @(negedge clk);
      if (m_armed) begin
        if (m_in_rst) begin
          chk("rst_instr_ready", {31'h0, instr_ready}, 32'h0);
          chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
          chk("rst_rf_re", {31'h0, rf_re}, 32'h0);
          chk("rst_rf_addr", {28'h0, rf_addr}, 32'h0);
          chk("rst_shift_data", Shift_Data, 32'h0);
          chk("rst_shift_num", {24'h0, Shift_Num}, 32'h0);
          chk("rst_shift_op", {29'h0, SHIFT_OP}, 32'h0);
          chk("rst_carry", {31'h0, Carry_flag}, 32'h0);
        end else begin
          chk("mon_instr_ready", {31'h0, instr_ready}, {31'h0, !m_busy});
          exp_ov = m_busy && (cyc >= m_vat);
          chk("mon_out_valid", {31'h0, out_valid}, {31'h0, exp_ov});
          if (exp_ov) begin
            chk("mon_shift_data", Shift_Data, m_d);
            chk("mon_shift_num", {24'h0, Shift_Num}, {24'h0, m_n});
            chk("mon_shift_op", {29'h0, SHIFT_OP}, {29'h0, m_op});
            chk("mon_carry", {31'h0, Carry_flag}, {31'h0, m_c});
          end
          exp_re = m_busy && !m_imm && ((cyc == m_acc) || (m_regsh && cyc == m_acc + 1));
          chk("mon_rf_re", {31'h0, rf_re}, {31'h0, exp_re});
          exp_addr = !exp_re ? m_last : (cyc == m_acc) ? m_rm : m_rs;
          chk("mon_rf_addr", {28'h0, rf_addr}, {28'h0, exp_addr});
          m_last = exp_addr;
        end
      end
      // Advance the model to the next rising edge.
      if (!rst_n) begin
        m_armed  = 1;
        m_in_rst = 1;
        m_busy   = 0;
        m_last   = 0;
      end else begin
        if (m_armed && !m_in_rst && !m_busy && instr_valid) begin
          model_cmd(instr, pc, m_d, m_n, m_op, lat);
          m_c     = cpsr_c;
          m_imm   = instr[25];
          m_regsh = instr[4];
          m_rm    = instr[3:0];
          m_rs    = instr[11:8];
          m_busy  = 1;
          m_acc   = cyc + 1;
          m_vat   = cyc + lat;
        end else if (m_busy && cyc >= m_vat && out_ready) begin
          m_busy = 0;
        end
        m_in_rst = 0;
      end
    end
  end

  task automatic run_cmd(input string nm, input logic [31:0] ins, input logic c,
                         input logic [31:0] p, input int exp_lat,
                         input logic [31:0] exp_d, input logic [7:0] exp_n,
                         input logic [2:0] exp_op, input int hold);
    int cnt;
    cnt = 0;
    while (!instr_ready && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({nm, "_ready_at_issue"}, {31'h0, instr_ready}, 32'h1);
    instr = ins; cpsr_c = c; pc = p; instr_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs so anything not latched at accept shows up.
    instr_valid = 1'b0; instr = 32'hFFFF_FFFF; cpsr_c = ~c; pc = 32'h0;
    cnt = 1;
    while (!out_valid && cnt < 12) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({nm, "_latency"}, 32'(cnt), 32'(exp_lat));
    chk({nm, "_data"}, Shift_Data, exp_d);
    chk({nm, "_num"}, {24'h0, Shift_Num}, {24'h0, exp_n});
    chk({nm, "_op"}, {29'h0, SHIFT_OP}, {29'h0, exp_op});
    chk({nm, "_carry"}, {31'h0, Carry_flag}, {31'h0, c});
    for (int i = 0; i < hold; i++) begin
      instr_valid = ~instr_valid;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    if (hold > 0) begin
      chk({nm, "_held_valid"}, {31'h0, out_valid}, 32'h1);
      chk({nm, "_held_data"}, Shift_Data, exp_d);
      chk({nm, "_held_ready"}, {31'h0, instr_ready}, 32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_released"}, {31'h0, out_valid}, 32'h0);
    chk({nm, "_ready_after"}, {31'h0, instr_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int i = 0; i < 16; i++) regs[i] = 32'h1111_0000 + 32'(i);
    regs[1]  = 32'h1234_5678;
    regs[2]  = 32'h0000_0104;
    regs[3]  = 32'h8000_0000;
    regs[15] = 32'hCAFE_F00D;
    rst_n = 1'b0; instr = 32'h0; instr_valid = 1'b0; cpsr_c = 1'b0;
    pc = 32'h0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_ready_in_reset", {31'h0, instr_ready}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("init_ready_after_release", {31'h0, instr_ready}, 32'h1);

    run_cmd("rot_imm", 32'hE3A004FF, 1'b1, 32'h0, 1, 32'h0000_00FF, 8'h08, 3'b110, 0);
    run_cmd("imm_asr2", 32'hE1A00143, 1'b0, 32'h0, 3, 32'h8000_0000, 8'h02, 3'b100, 0);
    run_cmd("reg_lsr", 32'hE1A00231, 1'b1, 32'h0, 4, 32'h1234_5678, 8'h04, 3'b011, 0);
    run_cmd("bp_reg_asr", 32'hE1A00352, 1'b0, 32'h0, 4, 32'h0000_0104, 8'h00, 3'b101, 5);
    run_cmd("rot_imm_r0", 32'hE3A000AB, 1'b0, 32'h0, 1, 32'h0000_00AB, 8'h00, 3'b110, 0);
    run_cmd("rrx_raw", 32'hE1A00062, 1'b1, 32'h0, 3, 32'h0000_0104, 8'h00, 3'b110, 0);
`ifdef OPERAND_PC_FWD_EN
    run_cmd("rm_r15", 32'hE1A0000F, 1'b0, 32'h0000_1000, 3, 32'h0000_1008, 8'h00, 3'b000, 0);
    run_cmd("rs_r15", 32'hE1A00F11, 1'b1, 32'h0000_1000, 4, 32'h1234_5678, 8'h08, 3'b001, 2);
`else
    run_cmd("rm_r15", 32'hE1A0000F, 1'b0, 32'h0000_1000, 3, 32'hCAFE_F00D, 8'h00, 3'b000, 0);
    run_cmd("rs_r15", 32'hE1A00F11, 1'b1, 32'h0000_1000, 4, 32'h1234_5678, 8'h0D, 3'b001, 2);
`endif

    // Reset while a command is being offered.
    instr = 32'hE1A00143; cpsr_c = 1'b1; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 12) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("rst_mid_valid_before", {31'h0, out_valid}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_mid_data", Shift_Data, 32'h0);
    chk("rst_mid_carry", {31'h0, Carry_flag}, 32'h0);
    chk("rst_mid_ready", {31'h0, instr_ready}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready_after", {31'h0, instr_ready}, 32'h1);
    run_cmd("post_rst", 32'hE3A004FF, 1'b1, 32'h0, 1, 32'h0000_00FF, 8'h08, 3'b110, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
